// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [31:0] len_t;
    typedef logic [10:0] widx_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

    // Byte address of word idx relative to an aligned base.
    function automatic len_t byte_addr(input len_t base, input widx_t idx);
        return base + {19'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects bytes LSB-first into a 32-bit word and flags the 4th byte.
// Ports: clk, reset (async, active-low), i_clear, i_en, i_byte,
//        o_word_next (word including the current byte), o_word_valid.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word_next,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    // Only the three most recent bytes are kept; the 4th arrives live.
    logic [23:0] r_part;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_part <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_part <= '0;
        end else if (i_en) begin
            r_cnt  <= r_cnt + 2'd1;
            r_part <= {i_byte, r_part[23:8]};
        end
    end

    assign o_word_next  = {i_byte, r_part};
    assign o_word_valid = i_en && !i_clear &&
                          (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed little-endian image into instruction memory
// and holds the core in reset while loading.
// Ports: clk, reset (async active-low), start, rx_valid/rx_data/rx_ready
//        byte stream; mem_we/mem_addr/mem_wdata memory write port;
//        cpu_hold, done, error, word_count status.
// Macro IMEM_LOADER_CHECKSUM_EN adds a 32-bit sum trailer after the data.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [10:0] word_count
);

    state_t r_state;
    state_t w_next;

    len_t  r_len;
    widx_t r_wcount;
    len_t  r_mem_addr;
    len_t  r_mem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    len_t  r_sum;
`endif

    logic  w_xfer;
    logic  w_start_ok;
    logic  w_last;
    logic  w_wvalid;
    len_t  w_word;

    assign w_xfer     = rx_valid && rx_ready;
    assign w_start_ok = start && (r_state == IDLE ||
                                  r_state == DONE ||
                                  r_state == ERR);
    assign w_last     = (len_t'(r_wcount) + 32'd1) == r_len;

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_en         (w_xfer),
        .i_byte       (rx_data),
        .o_word_next  (w_word),
        .o_word_valid (w_wvalid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE, ERR: begin
                if (start) w_next = LEN;
            end
            LEN: begin
                if (w_wvalid) begin
                    if (w_word > len_t'(MEM_WORDS))
                        w_next = ERR;
                    else if (w_word == '0)
`ifdef IMEM_LOADER_CHECKSUM_EN
                        w_next = CSUM;
`else
                        w_next = DONE;
`endif
                    else
                        w_next = DATA;
                end
            end
            DATA: begin
                if (w_wvalid) w_next = WRITE;
            end
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w_next = w_last ? CSUM : DATA;
`else
                w_next = w_last ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (w_wvalid) w_next = (w_word == r_sum) ? DONE : ERR;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        cpu_hold = 1'b0;
        mem_we   = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        unique case (r_state)
            LEN, DATA: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                cpu_hold = 1'b1;
                mem_we   = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                cpu_hold = 1'b1;
            end
`endif
            DONE:    done = 1'b1;
            ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Address/data are latched with the 4th byte so they are stable
    // through WRITE and keep their value afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len       <= '0;
            r_wcount    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            if (w_start_ok) begin
                r_wcount <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum    <= '0;
`endif
            end
            if (r_state == LEN && w_wvalid)
                r_len <= w_word;
            if (r_state == DATA && w_wvalid) begin
                r_mem_addr  <= byte_addr(BASE_ADDR, r_wcount);
                r_mem_wdata <= w_word;
            end
            if (r_state == WRITE) begin
                if (r_wcount != widx_t'(MEM_WORDS))
                    r_wcount <= r_wcount + 11'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_sum <= r_sum + r_mem_wdata;
`endif
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_wcount;

endmodule
